// File: rtl/mcml_step_pkg.sv
// Shared constants for the photon step-size stage: fixed-point formats, ln(2) scaling and the
// saturation value. The optional saturation counter is enabled by defining STEP_SAT_COUNT_EN.
package mcml_step_pkg;

  localparam int unsigned BIT_WIDTH     = 32;
  localparam int unsigned PROD_WIDTH    = 64;
  localparam int unsigned SAT_CNT_WIDTH = 16;

  // Q5.27 log input and Q16.16 attenuation / step
  localparam int unsigned Q5_27_INT   = 5;
  localparam int unsigned FRAC_LOG    = 27;
  localparam int unsigned Q16_16_INT  = 16;
  localparam int unsigned Q16_16_FRAC = 16;

  localparam logic [31:0] LOG2           = 32'd93032639;
  localparam logic [31:0] NEG_LOG_OFFSET = 32'd2977044448;
  localparam logic [31:0] SAT_VALUE      = 32'hFFFF_FFFF;

  // -ln(x/2^32) in Q5.27; inputs above 32*ln2 cannot come from a valid log, so clamp to zero
  function automatic logic [31:0] neg_log_f(input logic [31:0] log_x);
    if (log_x > NEG_LOG_OFFSET) begin
      return 32'd0;
    end else begin
      return NEG_LOG_OFFSET - log_x;
    end
  endfunction

endpackage

// File: rtl/step_mult.sv
// Registered unsigned W x W -> 2W multiply with clock enable; a drop-in point for a DSP macro.
module step_mult #(
  parameter int unsigned W = 32
) (
  input  logic           clock,
  input  logic           en,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  logic [2*W-1:0] p_q;
  logic [2*W-1:0] p_d;

  always_comb begin
    p_d = p_q;
    if (en) begin
      p_d = (2*W)'(a) * (2*W)'(b);
    end
  end

  always_ff @(posedge clock) begin
    p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/step_size_calc.sv
// Photon step size s = -ln(x/2^32) / mu_t as a 3-stage valid/ready pipeline with a global stall.
// Defining STEP_SAT_COUNT_EN adds the sat_count port counting saturated output handshakes.
module step_size_calc
  import mcml_step_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BIT_WIDTH-1:0]     in_log_x,
  input  logic [BIT_WIDTH-1:0]     mu_t_inv,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BIT_WIDTH-1:0]     out_step
`ifdef STEP_SAT_COUNT_EN
  ,
  output logic [SAT_CNT_WIDTH-1:0] sat_count
`endif
);

  localparam int unsigned STEP_LSB = FRAC_LOG;
  localparam int unsigned STEP_MSB = FRAC_LOG + BIT_WIDTH - 1;

  logic                  advance_s;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s2_valid_q, s2_valid_d;
  logic                  s3_valid_q, s3_valid_d;
  logic [BIT_WIDTH-1:0]  neg_log_q, neg_log_d;
  logic [BIT_WIDTH-1:0]  mu_q, mu_d;
  logic [PROD_WIDTH-1:0] prod_s;
  logic                  sat_s;
  logic [BIT_WIDTH-1:0]  out_step_q, out_step_d;
  logic                  unused_prod_s;

  assign advance_s = !s3_valid_q || out_ready;
  assign in_ready  = advance_s;
  assign out_valid = s3_valid_q;
  assign out_step  = out_step_q;

  // Flush drops everything in flight, including a token offered this cycle
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s3_valid_d = s3_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      s3_valid_d = 1'b0;
    end else if (advance_s) begin
      s1_valid_d = in_valid;
      s2_valid_d = s1_valid_q;
      s3_valid_d = s2_valid_q;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
    end
  end

  always_comb begin
    neg_log_d = neg_log_q;
    mu_d      = mu_q;
    if (advance_s) begin
      neg_log_d = neg_log_f(in_log_x);
      mu_d      = mu_t_inv;
    end
  end

  always_ff @(posedge clock) begin
    neg_log_q <= neg_log_d;
    mu_q      <= mu_d;
  end

  step_mult #(.W(BIT_WIDTH)) u_step_mult (
    .clock (clock),
    .en    (advance_s),
    .a     (neg_log_q),
    .b     (mu_q),
    .p     (prod_s)
  );

  // Q5.27 * Q16.16 carries 43 fraction bits; dropping 27 leaves Q16.16, anything above overflows
  assign sat_s         = |prod_s[PROD_WIDTH-1:STEP_MSB+1];
  assign unused_prod_s = ^prod_s[STEP_LSB-1:0];

  always_comb begin
    out_step_d = out_step_q;
    if (advance_s) begin
      out_step_d = sat_s ? SAT_VALUE : prod_s[STEP_MSB:STEP_LSB];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_step_q <= '0;
    end else begin
      out_step_q <= out_step_d;
    end
  end

`ifdef STEP_SAT_COUNT_EN
  logic                     sat_flag_q, sat_flag_d;
  logic [SAT_CNT_WIDTH-1:0] sat_count_q, sat_count_d;

  // Counter survives flush and sticks at all-ones
  always_comb begin
    sat_flag_d  = sat_flag_q;
    sat_count_d = sat_count_q;
    if (advance_s) begin
      sat_flag_d = sat_s;
    end
    if (s3_valid_q && out_ready && sat_flag_q && (sat_count_q != {SAT_CNT_WIDTH{1'b1}})) begin
      sat_count_d = sat_count_q + SAT_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sat_flag_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      sat_flag_q  <= sat_flag_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_step_size_calc.sv
// Directed self-checking bench for step_size_calc; follows STEP_SAT_COUNT_EN for the sat_count port.
module tb_step_size_calc;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_log_x;
  logic [31:0] mu_t_inv;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_step;
`ifdef STEP_SAT_COUNT_EN
  logic [15:0] sat_count;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] OFFSET   = 32'd2977044448;
  localparam logic [31:0] ONE_Q527 = 32'd134217728;
  localparam logic [31:0] MAX_STEP = 32'h0016_2E42;

  always #5 clock = ~clock;

  step_size_calc dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_log_x  (in_log_x),
    .mu_t_inv  (mu_t_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_step  (out_step)
`ifdef STEP_SAT_COUNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_log_x = 32'd0; mu_t_inv = 32'd0;
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_step !== 32'd0) begin bad++; $display("FAIL reset_step got=%h exp=0", out_step); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef STEP_SAT_COUNT_EN
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL reset_sat got=%0d exp=0", sat_count); end
`endif
    reset = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    in_valid = 1'b1; in_log_x = 32'd0; mu_t_inv = 32'h0001_0000;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_n1 got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_n2 got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_n3 got=%b exp=1", out_valid); end
    total++; if (out_step !== MAX_STEP) begin bad++; $display("FAIL lat_step got=%h exp=%h", out_step, MAX_STEP); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_pop got=%b exp=0", out_valid); end
  endtask

  task automatic test_vectors();
    logic [31:0] lx [6];
    logic [31:0] mu [6];
    logic [31:0] ex [6];
    lx[0] = OFFSET;                  mu[0] = 32'h0001_0000; ex[0] = 32'd0;
    lx[1] = 32'hFFFF_FFFF;           mu[1] = 32'h0001_0000; ex[1] = 32'd0;
    lx[2] = 32'd0;                   mu[2] = 32'hFFFF_FFFF; ex[2] = 32'hFFFF_FFFF;
    lx[3] = OFFSET - ONE_Q527;       mu[3] = 32'h0002_3000; ex[3] = 32'h0002_3000;
    lx[4] = 32'h1000_0000;           mu[4] = 32'h0000_8000; ex[4] = 32'd661281;
    lx[5] = 32'd5;                   mu[5] = 32'd0;         ex[5] = 32'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int n;
      in_valid = 1'b1; in_log_x = lx[i]; mu_t_inv = mu[i];
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
        tick();
        n++;
      end
      total++;
      if (out_valid !== 1'b1) begin
        bad++; $display("FAIL vec%0d_timeout got_valid=%b exp=1", i, out_valid);
      end else if (out_step !== ex[i]) begin
        bad++; $display("FAIL vec%0d_step got=%h exp=%h", i, out_step, ex[i]);
      end
      tick();
    end
`ifdef STEP_SAT_COUNT_EN
    total++; if (sat_count !== 16'd1) begin bad++; $display("FAIL sat_count got=%0d exp=1", sat_count); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] ex [6];
    int sent;
    int recv;
    sent = 0;
    recv = 0;
    for (int k = 0; k < 6; k++) ex[k] = 32'(k + 1) << 16;
    mu_t_inv = 32'h0001_0000;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      in_valid  = (sent < 6);
      in_log_x  = OFFSET - 32'(sent + 1) * ONE_Q527;
      out_ready = !(c >= 5 && c < 10);
      #1;
      if (out_valid && !out_ready) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready c=%0d got=%b exp=0", c, in_ready); end
        total++; if (out_step !== ex[recv]) begin bad++; $display("FAIL b2b_hold c=%0d got=%h exp=%h", c, out_step, ex[recv]); end
      end
      if (out_valid && out_ready) begin
        total++;
        if (out_step !== ex[recv]) begin bad++; $display("FAIL b2b_out%0d got=%h exp=%h", recv, out_step, ex[recv]); end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (recv !== 6) begin bad++; $display("FAIL b2b_count got=%0d exp=6", recv); end
    tick(); tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_extra got=%b exp=0", out_valid); end
  endtask

  task automatic fill_three();
    out_ready = 1'b0;
    in_valid = 1'b1; in_log_x = 32'd0; mu_t_inv = 32'hFFFF_FFFF;
    tick(); tick(); tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset_inflight();
    fill_three();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_fill got=%b exp=1", out_valid); end
    reset = 1'b0;
    tick();
    reset = 1'b1; out_ready = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (out_step !== 32'd0) begin bad++; $display("FAIL rst_step got=%h exp=0", out_step); end
`ifdef STEP_SAT_COUNT_EN
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL rst_sat got=%0d exp=0", sat_count); end
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_ghost%0d got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_flush();
    fill_three();
    flush = 1'b1; in_valid = 1'b1; in_log_x = 32'd0; mu_t_inv = 32'h0001_0000;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost%0d got=%b exp=0", i, out_valid); end
      tick();
    end
    in_valid = 1'b1; in_log_x = 32'd0; mu_t_inv = 32'h0001_0000;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_lat1 got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_lat2 got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_lat3 got=%b exp=1", out_valid); end
    total++; if (out_step !== MAX_STEP) begin bad++; $display("FAIL flush_step got=%h exp=%h", out_step, MAX_STEP); end
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_reset_inflight();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
